// File: rtl/jts16_pal_sched_if.sv
// CPU palette bus between the memory map decoder and the palette scheduler.
// Parameters: AW (word address width), DW (word width).
// Signals: cpu_cs level request, cpu_we 1=write, cpu_dsn active-low byte
// strobes ([1]=upper), cpu_addr word address, cpu_dout write data,
// cpu_din read data, cpu_ok one-cycle acknowledge.
// master = CPU side, slave = scheduler side.
interface jts16_pal_sched_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
);
  logic          cpu_cs;
  logic          cpu_we;
  logic [1:0]    cpu_dsn;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic [DW-1:0] cpu_din;
  logic          cpu_ok;

  modport master (
    output cpu_cs, cpu_we, cpu_dsn, cpu_addr, cpu_dout,
    input  cpu_din, cpu_ok
  );

  modport slave (
    input  cpu_cs, cpu_we, cpu_dsn, cpu_addr, cpu_dout,
    output cpu_din, cpu_ok
  );
endinterface

// File: rtl/jts16_pal_sched.sv
// Single-port palette RAM scheduler: video lookups own the port on every
// pxl_cen cycle, CPU accesses use the remaining cycles and get a one-cycle
// cpu_ok acknowledge.
// Optional feature: define JTS16_PALCLR_EN to zero the whole palette after
// reset (busy=1) before the CPU is admitted.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pxl_cen, vid_addr video lookup enable and palette index
//   vid_data          palette word of the last video lookup (registered)
//   cpu               CPU bus (jts16_pal_sched_if.slave)
//   busy              clear sequence running
//   ram_addr/din/we   RAM port, driven combinationally for the current cycle
//   ram_dout          RAM read data, valid the cycle after the address
module jts16_pal_sched #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic [AW-1:0]     vid_addr,
  output logic [DW-1:0]     vid_data,
  jts16_pal_sched_if.slave  cpu,
  output logic              busy,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic [1:0]        ram_we,
  input  logic [DW-1:0]     ram_dout
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_CPU_RD = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

`ifdef JTS16_PALCLR_EN
  localparam state_t ST_RST = ST_CLEAR;
`else
  localparam state_t ST_RST = ST_IDLE;
`endif

  state_t        state, state_nx;
  logic          armed, armed_nx;
  logic          vid_tag;
  logic          cpu_ok_nx;
  logic [DW-1:0] vid_data_nx, cpu_din_nx;

`ifdef JTS16_PALCLR_EN
  logic [AW-1:0] clr_cnt, clr_cnt_nx;
  logic          busy_nx;
`endif

  // Next-state, next-output and RAM port ownership for this cycle
  always_comb begin
    state_nx    = state;
    armed_nx    = armed;
    cpu_ok_nx   = 1'b0;
    vid_data_nx = vid_tag ? ram_dout : vid_data;
    cpu_din_nx  = cpu.cpu_din;
    ram_addr    = '0;
    ram_din     = '0;
    ram_we      = 2'b00;
`ifdef JTS16_PALCLR_EN
    clr_cnt_nx  = clr_cnt;
    busy_nx     = busy;
`endif

    // A request is armed again only once cpu_cs has been seen low
    if (!cpu.cpu_cs) armed_nx = 1'b1;

    case (state)
      ST_CLEAR: begin
`ifdef JTS16_PALCLR_EN
        if (!pxl_cen) begin
          ram_addr   = clr_cnt;
          ram_we     = 2'b11;
          clr_cnt_nx = AW'(clr_cnt + 1'b1);
          if (&clr_cnt) begin
            state_nx = ST_IDLE;
            busy_nx  = 1'b0;
          end
        end
`else
        state_nx = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (!pxl_cen && cpu.cpu_cs && armed) begin
          ram_addr = cpu.cpu_addr;
          armed_nx = 1'b0;
          if (cpu.cpu_we) begin
            ram_we    = ~cpu.cpu_dsn;
            ram_din   = cpu.cpu_dout;
            cpu_ok_nx = 1'b1;
            state_nx  = ST_ACK;
          end else begin
            state_nx  = ST_CPU_RD;
          end
        end
      end
      // ram_dout now carries the CPU-addressed word from the accept cycle
      ST_CPU_RD: begin
        cpu_din_nx = ram_dout;
        cpu_ok_nx  = 1'b1;
        state_nx   = ST_ACK;
      end
      ST_ACK: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Video always wins the port on a pixel enable
    if (pxl_cen) begin
      ram_addr = vid_addr;
      ram_din  = '0;
      ram_we   = 2'b00;
    end

    // Keep the RAM port quiet while reset is held
    if (!rst_n) begin
      ram_addr = '0;
      ram_din  = '0;
      ram_we   = 2'b00;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RST;
      armed       <= 1'b1;
      vid_tag     <= 1'b0;
      vid_data    <= '0;
      cpu.cpu_din <= '0;
      cpu.cpu_ok  <= 1'b0;
    end else begin
      state       <= state_nx;
      armed       <= armed_nx;
      vid_tag     <= pxl_cen;
      vid_data    <= vid_data_nx;
      cpu.cpu_din <= cpu_din_nx;
      cpu.cpu_ok  <= cpu_ok_nx;
    end
  end

`ifdef JTS16_PALCLR_EN
  // Clear address counter and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      clr_cnt <= clr_cnt_nx;
      busy    <= busy_nx;
    end
  end
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_jts16_pal_sched.sv
module tb_jts16_pal_sched;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

`ifdef JTS16_PALCLR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pxl_cen = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_dout = '0;

  jts16_pal_sched_if #(.AW(AW), .DW(DW)) cpu_bus ();

  jts16_pal_sched #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .vid_addr (vid_addr),
    .vid_data (vid_data),
    .cpu      (cpu_bus),
    .busy     (busy),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous palette RAM with byte enables
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we[1]) mem[ram_addr][15:8] = ram_din[15:8];
    if (ram_we[0]) mem[ram_addr][7:0]  = ram_din[7:0];
  end

  typedef struct {
    logic          rd;
    logic [DW-1:0] data;
    int            lat;   // cycles from cpu_cs rise to cpu_ok, -1 = unchecked
  } exp_t;

  exp_t          cpu_q[$];
  logic [DW-1:0] vid_q[$];
  int            errors = 0;
  int            checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor / scoreboard
  int            cyc = 0;
  int            rise_cyc = 0;
  logic          cs_prev = 1'b0;
  logic          p1 = 1'b0, p2 = 1'b0;
  logic [DW-1:0] last_vid = '0, last_din = '0;

  always @(negedge clk) begin
    exp_t e;
    logic [DW-1:0] v;
    cyc++;
    if (!rst_n) begin
      p1 = 1'b0; p2 = 1'b0; cs_prev = 1'b0;
      last_vid = '0; last_din = '0;
    end else begin
      if (cpu_bus.cpu_cs && !cs_prev) rise_cyc = cyc;
      cs_prev = cpu_bus.cpu_cs;
      if (p2) begin
        if (vid_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL vid_unexpected: got %h with no lookup pending", vid_data);
        end else begin
          v = vid_q.pop_front();
          last_vid = v;
        end
      end
      p2 = p1;
      p1 = pxl_cen;
      if (cpu_bus.cpu_ok) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_ok_unexpected: got cpu_ok=1 at cycle %0d with nothing pending", cyc);
        end else begin
          e = cpu_q.pop_front();
          if (e.lat >= 0) chk("cpu_latency", 32'(cyc - rise_cyc), 32'(e.lat));
          if (e.rd) last_din = e.data;
        end
      end
    end
    chk("vid_data", 32'(vid_data), 32'(last_vid));
    chk("cpu_din", 32'(cpu_bus.cpu_din), 32'(last_din));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input int n);
    for (int i = 0; i < n && cpu_q.size() != 0; i++) begin
      step();
      pxl_cen = 1'b0;
    end
    if (cpu_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL cpu_timeout: got %0d pending, expected 0", cpu_q.size());
      cpu_q.delete();
    end
  endtask

  task automatic cpu_acc(input logic we, input logic [1:0] dsn, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp, input int lat);
    exp_t e;
    e.rd = !we; e.data = exp; e.lat = lat;
    cpu_q.push_back(e);
    cpu_bus.cpu_cs = 1'b1; cpu_bus.cpu_we = we; cpu_bus.cpu_dsn = dsn;
    cpu_bus.cpu_addr = a; cpu_bus.cpu_dout = d;
    wait_sb(40);
    cpu_bus.cpu_cs = 1'b0;
    step();
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vid_data"}, 32'(vid_data), 32'h0);
    chk({tag, "_cpu_din"},  32'(cpu_bus.cpu_din), 32'h0);
    chk({tag, "_cpu_ok"},   32'(cpu_bus.cpu_ok), 32'h0);
    chk({tag, "_ram_we"},   32'(ram_we), 32'h0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    chk({tag, "_ram_din"},  32'(ram_din), 32'h0);
    chk({tag, "_busy"},     32'(busy), 32'(BUSY_RST));
  endtask

  task automatic preload_pattern();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hC000 | 16'(i);
    mem[11'h010] = 16'hAAAA;
  endtask

  task automatic wait_clear_done();
    for (int i = 0; i < 3000 && busy; i++) step();
    chk("busy_done", 32'(busy), 32'h0);
  endtask

  initial begin
    exp_t e;
    cpu_bus.cpu_cs = 1'b0; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_dsn = 2'b11;
    cpu_bus.cpu_addr = '0; cpu_bus.cpu_dout = '0;
`ifdef JTS16_PALCLR_EN
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hFFFF;
`else
    preload_pattern();
`endif
    // Reset state, with a pixel enable that must not reach the RAM port
    step();
    pxl_cen = 1'b1; vid_addr = 11'h123;
    #1;
    chk_reset_outputs("reset");
    pxl_cen = 1'b0;
    step();
    rst_n = 1'b1;

`ifdef JTS16_PALCLR_EN
    begin
      int wc, early;
      wc = 0; early = 0;
      step();
      e.rd = 1'b1; e.data = 16'h0000; e.lat = -1;
      cpu_q.push_back(e);
      cpu_bus.cpu_cs = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 11'h100;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (!busy) break;
        if (ram_we == 2'b11) wc++;
        if (cpu_bus.cpu_ok) early++;
      end
      chk("clear_writes", 32'(wc), 32'd2047);
      chk("clear_ok_early", 32'(early), 32'h0);
      step();
      wait_sb(20);
      cpu_bus.cpu_cs = 1'b0;
      step();
      chk("clear_mem_000", 32'(mem[11'h000]), 32'h0);
      chk("clear_mem_155", 32'(mem[11'h155]), 32'h0);
      chk("clear_mem_7ff", 32'(mem[11'h7FF]), 32'h0);
      preload_pattern();
      step();
    end
`endif
    step();

    // Write then read back
    cpu_acc(1'b1, 2'b00, 11'h7FF, 16'h1234, 16'h0000, 1);
    cpu_acc(1'b0, 2'b00, 11'h7FF, 16'h0000, 16'h1234, 2);
    // Byte lanes: only the lower byte is written
    cpu_acc(1'b1, 2'b10, 11'h010, 16'h5555, 16'h0000, 1);
    cpu_acc(1'b0, 2'b00, 11'h010, 16'h0000, 16'hAA55, 2);
    // No strobes: acknowledged, RAM untouched
    cpu_acc(1'b1, 2'b11, 11'h020, 16'h0000, 16'h0000, 1);
    cpu_acc(1'b0, 2'b00, 11'h020, 16'h0000, 16'hC020, 2);

    // Collision: video wins this cycle, CPU accepted the next one
    pxl_cen = 1'b1; vid_addr = 11'h010;
    vid_q.push_back(16'hAA55);
    cpu_bus.cpu_cs = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 11'h7FF;
    #1;
    chk("collision_ram_addr", 32'(ram_addr), 32'h010);
    chk("collision_ram_we", 32'(ram_we), 32'h0);
    cpu_acc(1'b0, 2'b00, 11'h7FF, 16'h0000, 16'h1234, 3);

    // Plain video lookups
    pxl_cen = 1'b1; vid_addr = 11'h005; vid_q.push_back(16'hC005);
    step(); pxl_cen = 1'b0; step();
    pxl_cen = 1'b1; vid_addr = 11'h7FF; vid_q.push_back(16'h1234);
    step(); pxl_cen = 1'b0; step(); step(); step();

    // Pixel enable during CPU_RD
    e.rd = 1'b1; e.data = 16'hAA55; e.lat = 2;
    cpu_q.push_back(e);
    cpu_bus.cpu_cs = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 11'h010;
    step();
    pxl_cen = 1'b1; vid_addr = 11'h003; vid_q.push_back(16'hC003);
    wait_sb(20);
    cpu_bus.cpu_cs = 1'b0;
    step(); step();

    // Held request: one acknowledge only
    e.rd = 1'b1; e.data = 16'hC005; e.lat = 2;
    cpu_q.push_back(e);
    cpu_bus.cpu_cs = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 11'h005;
    repeat (20) step();
    cpu_bus.cpu_cs = 1'b0;
    step(); step();
    chk("held_pending", 32'(cpu_q.size()), 32'h0);
    chk("vid_pending", 32'(vid_q.size()), 32'h0);

    // Reset in CPU_RD aborts the read
    cpu_bus.cpu_cs = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 11'h7FF;
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    cpu_bus.cpu_cs = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
`ifdef JTS16_PALCLR_EN
    wait_clear_done();
`endif
    repeat (5) step();
    chk("end_cpu_pending", 32'(cpu_q.size()), 32'h0);
    chk("end_vid_pending", 32'(vid_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jts16_pal_sched.md
# jts16_pal_sched

Schedules the single-port palette RAM between the video pixel path and the 68000 CPU bus. Video lookups own the port on every `pxl_cen` cycle. CPU reads and writes use the remaining cycles, and the CPU sees a handshake acknowledge. An optional power-up sequencer zeroes the whole palette before the CPU is admitted. The block sits between the CPU memory map decoder, the colour mixer and the palette RAM instance.

## Interface
Parameters:
- `AW`, 11, palette address width (words)
- `DW`, 16, palette word width

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pxl_cen`  in  1  pixel clock enable; never high on two consecutive `clk` cycles
- `vid_addr`  in  AW  palette index from the colour mixer, sampled when `pxl_cen`=1
- `vid_data`  out  DW  palette word for the last video lookup
- `cpu_cs`  in  1  CPU palette access request, level
- `cpu_we`  in  1  1=write, 0=read
- `cpu_dsn`  in  2  active-low byte strobes, [1]=upper byte
- `cpu_addr`  in  AW  CPU word address
- `cpu_dout`  in  DW  CPU write data
- `cpu_din`  out  DW  CPU read data
- `cpu_ok`  out  1  one-cycle acknowledge pulse
- `busy`  out  1  clear sequence running
- `ram_addr`  out  AW  RAM address
- `ram_din`  out  DW  RAM write data
- `ram_we`  out  2  RAM byte write enables, [1]=upper byte
- `ram_dout`  in  DW  RAM read data; synchronous, valid the cycle after the address

## Operation
- Port owner per cycle:
  - If `pxl_cen`=1: video read. `ram_addr`=`vid_addr`, `ram_we`=0.
  - Else, when the clear sequence is active: clear write.
  - Else, when a CPU access is armed: CPU access.
  - Otherwise idle: `ram_we`=0.
- States: CLEAR, IDLE, CPU_RD, ACK.
- IDLE → accept a CPU request when `cpu_cs`=1, the request is armed, and `pxl_cen`=0.
  - Write: `ram_we`=~`cpu_dsn` and `ram_din`=`cpu_dout` in that cycle, then go to ACK.
  - Read: `ram_we`=0, go to CPU_RD.
- CPU_RD: latch `ram_dout` into `cpu_din`, go to ACK.
- ACK: `cpu_ok`=1 for exactly one cycle, disarm, go to IDLE.
- Arming: rearm only after `cpu_cs` is sampled low for at least one cycle. A held `cpu_cs` never produces a second `cpu_ok`.
- `cpu_dsn`=2'b11 on a write: the access is acknowledged, and `ram_we` stays 0.
- Read-tag pipeline: a 1-bit tag marks whether the previous cycle's RAM read was video. When the tag is set, `vid_data` loads `ram_dout`. `cpu_din` loads only in CPU_RD.
- CPU data is never returned from a video-tagged read, and video data never from a CPU-tagged read.

## Timing
- Reset values: `vid_data`=0, `cpu_din`=0, `cpu_ok`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0.
  - `busy`=1 when `JTS16_PALCLR_EN` is defined, otherwise 0.
  - State = CLEAR when `JTS16_PALCLR_EN` is defined, otherwise IDLE.
- Video: `pxl_cen` at cycle N → `vid_data` updated at the N+1 clock edge, visible from N+2. `vid_data` holds until the next lookup.
- CPU write accepted at cycle M → `cpu_ok`=1 in cycle M+1.
- CPU read accepted at cycle M → `cpu_din` valid and `cpu_ok`=1 in cycle M+2. `cpu_din` holds until the next CPU read.
- A `pxl_cen` arriving while in CPU_RD or ACK does not disturb the CPU result. The CPU already owns no port cycle in those states.
- Worst-case CPU wait before acceptance: 1 cycle, due to a `pxl_cen` collision, when not in CLEAR.
- Reset asserted mid-operation: the access is aborted immediately, outputs return to reset values, and no `cpu_ok` is issued.

## Configuration
- `JTS16_PALCLR_EN` defined:
  - After reset the block starts in CLEAR. An AW-bit counter starts at 0 and writes 0 with `ram_we`=2'b11 on each non-`pxl_cen` cycle, then increments.
  - After the write to address 2^AW−1 the counter wraps to 0, `busy` drops to 0 on the next cycle, and the state becomes IDLE.
  - Video lookups are still served during CLEAR. CPU requests stay pending (no `cpu_ok`) until CLEAR ends.
- `JTS16_PALCLR_EN` undefined: no counter, `busy` is tied to 0, and the block starts in IDLE.

## Test plan
- Write then read: write 16'h1234 to 0x7FF with `cpu_dsn`=00, drop `cpu_cs`, then read 0x7FF → `cpu_ok` arrives 1 cycle after the write is accepted. For the read, `cpu_din`=16'h1234 with `cpu_ok` 2 cycles after acceptance.
- Byte lanes: pre-load 0x010 with 16'hAAAA, write 16'h5555 with `cpu_dsn`=2'b10 → read returns 16'hAA55.
- Collision: `cpu_cs` rises in the same cycle as `pxl_cen` with `vid_addr`=0x010 → video `ram_addr`=0x010 first, the CPU is accepted the next cycle, and `vid_data` and `cpu_din` each receive their own word.
- Held request: `cpu_cs` held high for 20 cycles on a read → exactly one `cpu_ok` pulse.
- Clear (macro on): preload RAM with 16'hFFFF, release `rst_n` → `busy` high for at least 2048 non-`pxl_cen` cycles, `ram_we`=11 on each. Afterwards every address reads 0. A CPU request issued during CLEAR is acknowledged only after `busy`=0.
- Reset mid-read: assert `rst_n`=0 in CPU_RD → `cpu_ok` is never pulsed and all outputs are at reset values within the same cycle.
